// File: rtl/sprinkler_zone_sequencer.sv
// Timed sprinkler zone sequencer driving a 3-to-8 valve decoder.
// Walks masked zones 0..7 with rain pause, dead gaps and stop abort.
module sprinkler_zone_sequencer #(
   parameter int ZONE_TICKS = 16,
   parameter int GAP_TICKS  = 4,
   parameter int CNT_W      = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       stop,
   input  logic [7:0] zone_mask,
   input  logic       rain_sense,
   output logic       enable,
   output logic       A,
   output logic       B,
   output logic       C,
   output logic       busy,
   output logic       done
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SEEK,
      S_WATER,
      S_GAP,
      S_DONE
   } state_t;

   localparam logic [CNT_W-1:0] ZONE_LOAD = CNT_W'(ZONE_TICKS - 1);
   localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_TICKS - 1);
   localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

   state_t           r_state;
   state_t           w_state_n;
   logic [CNT_W-1:0] r_timer;
   logic [CNT_W-1:0] w_timer_n;
   logic [7:0]       r_mask;
   logic [7:0]       w_mask_n;
   logic [2:0]       r_zidx;
   logic [2:0]       w_zidx_n;
   logic             r_en;
   logic             w_en_n;
   logic             r_busy;
   logic             w_busy_n;
   logic             r_done;
   logic             w_done_n;

   // Next-state, timer, zone index and next registered outputs.
   always_comb begin
      w_state_n = r_state;
      w_timer_n = r_timer;
      w_mask_n  = r_mask;
      w_zidx_n  = r_zidx;
      w_en_n    = 1'b0;
      w_done_n  = 1'b0;
      if (stop) begin
         w_state_n = S_IDLE;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (start) begin
                  w_mask_n  = zone_mask;
                  w_zidx_n  = 3'd0;
                  w_state_n = S_SEEK;
               end
            end
            S_SEEK: begin
               if (r_mask[r_zidx]) begin
                  w_state_n = S_WATER;
                  w_timer_n = ZONE_LOAD;
                  w_en_n    = 1'b1;
               end else if (r_zidx == 3'd7) begin
                  w_state_n = S_DONE;
               end else begin
                  w_zidx_n  = r_zidx + 3'd1;
               end
            end
            S_WATER: begin
               if (!rain_sense) begin
                  if (r_timer == '0) begin
                     w_state_n = S_GAP;
                     w_timer_n = GAP_LOAD;
                  end else begin
                     w_timer_n = r_timer - ONE;
                     w_en_n    = 1'b1;
                  end
               end
            end
            S_GAP: begin
               if (r_timer == '0) begin
                  if (r_zidx == 3'd7) begin
                     w_state_n = S_DONE;
                  end else begin
                     w_zidx_n  = r_zidx + 3'd1;
                     w_state_n = S_SEEK;
                  end
               end else begin
                  w_timer_n = r_timer - ONE;
               end
            end
            S_DONE: begin
               w_state_n = S_IDLE;
               w_done_n  = 1'b1;
            end
            default: begin
               w_state_n = S_IDLE;
            end
         endcase
      end
      w_busy_n = (w_state_n != S_IDLE) && (w_state_n != S_DONE);
   end

   // State register and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_timer <= '0;
         r_mask  <= '0;
         r_zidx  <= '0;
         r_en    <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_n;
         r_timer <= w_timer_n;
         r_mask  <= w_mask_n;
         r_zidx  <= w_zidx_n;
         r_en    <= w_en_n;
         r_busy  <= w_busy_n;
         r_done  <= w_done_n;
      end
   end

   assign enable    = r_en;
   assign {A, B, C} = r_zidx;
   assign busy      = r_busy;
   assign done      = r_done;

endmodule

// File: tb/tb_sprinkler_zone_sequencer.sv
// Directed bench for the sprinkler zone sequencer.
// ZONE_TICKS=4, GAP_TICKS=2; samples on the falling clock edge.
module tb_sprinkler_zone_sequencer;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic       stop;
   logic [7:0] zone_mask;
   logic       rain_sense;
   logic       enable;
   logic       A;
   logic       B;
   logic       C;
   logic       busy;
   logic       done;

   int n_checks;
   int n_fail;

   int en_cnt[8];
   int en_total;
   int done_cnt;
   int busy_cnt;
   int first_en;
   int end_i;
   int viol;
   int min_low;
   int max_high;

   sprinkler_zone_sequencer #(
      .ZONE_TICKS(4),
      .GAP_TICKS (2),
      .CNT_W     (16)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .stop      (stop),
      .zone_mask (zone_mask),
      .rain_sense(rain_sense),
      .enable    (enable),
      .A         (A),
      .B         (B),
      .C         (C),
      .busy      (busy),
      .done      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Called right after a falling edge; returns at sample 0 (after edge k).
   task automatic go(input logic [7:0] m);
      zone_mask = m;
      start     = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start     = 1'b0;
   endtask

   task automatic run_mon(input int maxc, input int ron, input int rlen,
                          input int son);
      logic [2:0] abc;
      logic [2:0] pabc;
      logic       pen;
      int         lowrun;
      int         highrun;
      bit         seen_high;
      for (int z = 0; z < 8; z++) en_cnt[z] = 0;
      en_total  = 0;
      done_cnt  = 0;
      busy_cnt  = 0;
      first_en  = -1;
      end_i     = -1;
      viol      = 0;
      min_low   = 1000;
      max_high  = 0;
      lowrun    = 0;
      highrun   = 0;
      seen_high = 1'b0;
      pabc      = {A, B, C};
      pen       = enable;
      for (int i = 0; i < maxc; i++) begin
         if (i > 0) @(negedge clk);
         abc = {A, B, C};
         if (i > 0 && abc != pabc && (enable || pen)) viol++;
         if (enable) begin
            en_cnt[abc]++;
            en_total++;
            if (first_en < 0) first_en = i;
            if (!pen && seen_high && lowrun < min_low) min_low = lowrun;
            highrun   = pen ? highrun + 1 : 1;
            if (highrun > max_high) max_high = highrun;
            seen_high = 1'b1;
            lowrun    = 0;
         end else begin
            lowrun = (i > 0 && pen) ? 1 : lowrun + 1;
         end
         if (busy) busy_cnt++;
         if (done) done_cnt++;
         pabc = abc;
         pen  = enable;
         if (done || (son >= 0 && i > son)) begin
            end_i = i;
            break;
         end
         rain_sense = (i >= ron && i < ron + rlen);
         stop       = (i == son);
      end
      rain_sense = 1'b0;
      stop       = 1'b0;
      if (end_i < 0) check("mon_timeout", 0, 1);
   endtask

   initial begin
      n_checks   = 0;
      n_fail     = 0;
      start      = 1'b0;
      stop       = 1'b0;
      zone_mask  = 8'h00;
      rain_sense = 1'b0;
      rst_n      = 1'b1;
      #2 rst_n   = 1'b0;
      #1;
      check("rst_enable", enable, 0);
      check("rst_abc", {A, B, C}, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // All zones
      go(8'hFF);
      check("ff_busy0", busy, 1);
      check("ff_en0", enable, 0);
      run_mon(200, -1, 0, -1);
      check("ff_first_en", first_en, 1);
      for (int z = 0; z < 8; z++)
         check($sformatf("ff_en_z%0d", z), en_cnt[z], 4);
      check("ff_en_total", en_total, 32);
      check("ff_min_low", min_low, 3);
      check("ff_max_high", max_high, 4);
      check("ff_done_cnt", done_cnt, 1);
      check("ff_done_at", end_i, 57);
      check("ff_busy_cnt", busy_cnt, 56);
      check("ff_idx_viol", viol, 0);
      check("ff_abc_end", {A, B, C}, 7);
      @(negedge clk);
      check("ff_done_pulse", done, 0);
      check("ff_idle_busy", busy, 0);

      // Zones 5 and 7 only
      go(8'hA0);
      run_mon(200, -1, 0, -1);
      check("a0_first_en", first_en, 6);
      check("a0_en_z5", en_cnt[5], 4);
      check("a0_en_z7", en_cnt[7], 4);
      check("a0_en_total", en_total, 8);
      check("a0_done_at", end_i, 21);
      check("a0_busy_cnt", busy_cnt, 20);
      check("a0_idx_viol", viol, 0);
      @(negedge clk);

      // Empty mask
      go(8'h00);
      run_mon(100, -1, 0, -1);
      check("m0_en_total", en_total, 0);
      check("m0_first_en", first_en, -1);
      check("m0_busy_cnt", busy_cnt, 8);
      check("m0_done_at", end_i, 9);
      check("m0_done_cnt", done_cnt, 1);
      @(negedge clk);
      check("m0_idle_busy", busy, 0);
      check("m0_idle_done", done, 0);

      // Zone 2 with a 3-cycle rain pause
      go(8'h04);
      run_mon(100, 4, 3, -1);
      check("rn_first_en", first_en, 3);
      check("rn_en_z2", en_cnt[2], 4);
      check("rn_en_total", en_total, 4);
      check("rn_pause_len", min_low, 3);
      check("rn_done_at", end_i, 18);
      check("rn_idx_viol", viol, 0);
      @(negedge clk);

      // Stop during zone 3 water
      go(8'hFF);
      run_mon(100, -1, 0, 23);
      check("st_end_i", end_i, 24);
      check("st_enable", enable, 0);
      check("st_busy", busy, 0);
      check("st_abc", {A, B, C}, 3);
      check("st_done_cnt", done_cnt, 0);
      check("st_en_z3", en_cnt[3], 2);
      repeat (3) @(negedge clk);
      check("st_no_done", done, 0);
      check("st_abc_hold", {A, B, C}, 3);
      go(8'h01);
      check("rs_abc0", {A, B, C}, 0);
      check("rs_busy", busy, 1);
      run_mon(100, -1, 0, -1);
      check("rs_first_en", first_en, 1);
      check("rs_en_z0", en_cnt[0], 4);
      check("rs_done_at", end_i, 15);
      @(negedge clk);

      // Asynchronous reset during zone 5 water
      go(8'hFF);
      repeat (37) @(negedge clk);
      check("ar_pre_en", enable, 1);
      check("ar_pre_abc", {A, B, C}, 5);
      #2 rst_n = 1'b0;
      #1;
      check("ar_enable", enable, 0);
      check("ar_abc", {A, B, C}, 0);
      check("ar_busy", busy, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      check("ar_idle_busy", busy, 0);
      check("ar_idle_en", enable, 0);
      go(8'h01);
      check("ar_restart_busy", busy, 1);
      run_mon(100, -1, 0, -1);
      check("ar_restart_done", end_i, 15);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
